// File: rtl/norm_shift_ctrl.sv
// Leading-one normalization control for a 16-bit shift register.
// Loads an operand, shifts left until MSB=1, reports shift count and zero flag.
module norm_shift_ctrl #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic             msb_in,
    output logic [WIDTH-1:0] par_in,
    output logic             ld,
    output logic             shl_en,
    output logic             shr_en,
    output logic             ser_in_l,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

    state_t state, next;
    logic   capture;
    logic   set_zero;

    assign shr_en   = 1'b0;
    assign ser_in_l = 1'b0;

    always_comb begin
        next     = state;
        capture  = 1'b0;
        set_zero = 1'b0;
        ld       = 1'b0;
        shl_en   = 1'b0;
        done     = 1'b0;
        busy     = (state != S_IDLE);
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    capture = 1'b1;
                    next    = S_LOAD;
                end
            end
            S_LOAD: begin
                ld = 1'b1;
                if (par_in == '0) begin
                    set_zero = 1'b1;
                    next     = S_DONE;
                end else begin
                    next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // msb_in is the register output, so this is still edge-clean
                if (msb_in) begin
                    next = S_DONE;
                end else if (shift_cnt == CNT_MAX) begin
                    next = S_DONE;
                end else begin
                    shl_en = 1'b1;
                end
            end
            S_DONE: begin
                done = 1'b1;
                next = S_IDLE;
            end
            default: next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            par_in    <= '0;
            shift_cnt <= '0;
            zero      <= 1'b0;
        end else begin
            state <= next;
            if (capture) begin
                par_in    <= data_in;
                shift_cnt <= '0;
                zero      <= 1'b0;
            end
            if (set_zero) begin
                zero <= 1'b1;
            end
            if (shl_en) begin
                shift_cnt <= shift_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_norm_shift_ctrl.sv
// Self-checking bench for norm_shift_ctrl with a behavioural shift register
// and a leading-zero-count reference model.
module tb_norm_shift_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] data_in = '0;
    logic        msb_in;
    logic [15:0] par_in;
    logic        ld, shl_en, shr_en, ser_in_l;
    logic [4:0]  shift_cnt;
    logic        zero, busy, done;

    logic [15:0] sreg = '0;

    int vectors = 0;
    int errs    = 0;

    norm_shift_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .data_in  (data_in),
        .msb_in   (msb_in),
        .par_in   (par_in),
        .ld       (ld),
        .shl_en   (shl_en),
        .shr_en   (shr_en),
        .ser_in_l (ser_in_l),
        .shift_cnt(shift_cnt),
        .zero     (zero),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ld)
            sreg <= par_in;
        else if (shl_en)
            sreg <= {sreg[14:0], 1'b0};
    end

    assign msb_in = sreg[15];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int lzc(input logic [15:0] v);
        int n = 0;
        if (v == 16'h0) return 0;
        while (v[15 - n] == 1'b0) n++;
        return n;
    endfunction

    // Runs one operation; start is raised again in cycle inj with inj_d.
    task automatic run_op(input string tag, input logic [15:0] d,
                          input int inj, input logic [15:0] inj_d);
        int k, exp_done, done_c, ld_c, ld_n, shl_n, shl_first, shl_last;
        int overlap, busy_bad;
        k = lzc(d);
        exp_done = (d == 16'h0) ? 2 : k + 3;
        done_c = -1; ld_c = -1; ld_n = 0; shl_n = 0;
        shl_first = -1; shl_last = -1; overlap = 0; busy_bad = 0;
        start = 1'b1;
        data_in = d;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (ld) begin
                ld_n++;
                ld_c = c;
            end
            if (shl_en) begin
                shl_n++;
                if (shl_first < 0) shl_first = c;
                shl_last = c;
            end
            if (ld && shl_en) overlap++;
            if (!busy) busy_bad++;
            start = (c == inj);
            if (c == inj) data_in = inj_d;
            if (done) begin
                done_c = c;
                break;
            end
        end
        check({tag, ".done_cycle"}, done_c, exp_done);
        check({tag, ".ld_cycle"}, ld_c, 1);
        check({tag, ".ld_count"}, ld_n, 1);
        check({tag, ".shl_count"}, shl_n, k);
        if (k > 0) begin
            check({tag, ".shl_first"}, shl_first, 2);
            check({tag, ".shl_last"}, shl_last, k + 1);
        end
        check({tag, ".shift_cnt"}, shift_cnt, k);
        check({tag, ".zero"}, zero, d == 16'h0);
        if (d != 16'h0)
            check({tag, ".sreg"}, sreg, d << k);
        check({tag, ".overlap"}, overlap, 0);
        check({tag, ".busy_run"}, busy_bad, 0);
        step();
        start = 1'b0;
        check({tag, ".idle_after"}, busy, 1'b0);
        check({tag, ".cnt_hold"}, shift_cnt, k);
    endtask

    initial begin
        #2;
        check("reset.busy", busy, 1'b0);
        check("reset.par_in", par_in, 16'h0);
        check("reset.cnt", shift_cnt, 5'd0);
        check("reset.zero", zero, 1'b0);
        check("reset.ctl", {ld, shl_en, done}, 3'b000);
        step();
        rst = 1'b1;
        step();

        run_op("msb_set", 16'h8000, 0, 16'h0);
        run_op("lsb_only", 16'h0001, 0, 16'h0);
        run_op("zero_op", 16'h0000, 0, 16'h0);
        run_op("busy_ign", 16'h00F0, 4, 16'h4000);
        run_op("after", 16'h4000, 0, 16'h0);
        // start coincident with done must be dropped
        run_op("done_ign", 16'h8000, 3, 16'h0001);
        check("const.shr", {shr_en, ser_in_l}, 2'b00);

        start = 1'b1;
        data_in = 16'h0001;
        for (int c = 1; c <= 6; c++) begin
            step();
            start = 1'b0;
        end
        #3;
        rst = 1'b0;
        #1;
        check("arst.busy", busy, 1'b0);
        check("arst.ctl", {ld, shl_en, done}, 3'b000);
        check("arst.cnt", shift_cnt, 5'd0);
        check("arst.par_in", par_in, 16'h0);
        check("arst.zero", zero, 1'b0);
        #2;
        rst = 1'b1;
        step();
        run_op("post_rst", 16'h0100, 0, 16'h0);

        for (int i = 0; i < 24; i++) begin
            logic [15:0] d;
            int sh, inj;
            sh = $urandom_range(0, 16);
            d = 16'($urandom) | 16'h8000;
            d = (sh == 16) ? 16'h0 : d >> sh;
            inj = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 4) : 0;
            run_op($sformatf("rnd%0d", i), d, inj, 16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/norm_shift_ctrl.md
Name: norm_shift_ctrl

Overview:
- Control stage directly upstream of the 16-bit shift register (ld / shl_en / shr_en / par_in / MSB_out interface).
- Loads an operand into that register, then shifts it left until its MSB is 1 (leading-one normalization), counting the shifts.
- Reports shift count and a zero flag to the downstream approximate-multiplier datapath, which uses them to truncate and later re-scale.
- Closed loop: drives the register's control pins and samples its MSB_out every cycle.

Parameters:
- WIDTH, 16, operand / shift-register width.
- CNT_W, 5, width of shift_cnt; must satisfy 2^CNT_W > WIDTH-1.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  request a normalization; sampled only in IDLE.
- data_in  input  WIDTH  operand, captured in the cycle start is accepted.
- msb_in  input  1  MSB_out of the shift register.
- par_in  output  WIDTH  operand driven to the shift register's parallel input (registered copy of data_in).
- ld  output  1  parallel-load strobe to the shift register.
- shl_en  output  1  shift-left strobe to the shift register.
- shr_en  output  1  shift-right strobe; constant 0 in this block.
- ser_in_l  output  1  serial fill bit; constant 0.
- shift_cnt  output  CNT_W  number of left shifts performed (leading-zero count).
- zero  output  1  operand was all zeros.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; par_in=0, shift_cnt=0, zero=0, ld=0, shl_en=0, done=0, busy=0. Applies mid-operation; the shift register's contents are then undefined to this block.
- All control outputs (ld, shl_en, done, busy) decode from registered state and are glitch-free. ld and shl_en are never high together.
- IDLE: if start=1, capture data_in into par_in, clear shift_cnt and zero, go to LOAD. start is ignored while busy=1.
- LOAD (1 cycle): ld=1.
  - If par_in==0: set zero=1, go to DONE.
  - Else: go to SHIFT.
- SHIFT (one cycle per evaluation):
  - msb_in reflects the register after the previous edge.
  - If msb_in=1: shl_en=0, go to DONE.
  - Else if shift_cnt==WIDTH-1: go to DONE (safety stop; unreachable for nonzero operands).
  - Else: shl_en=1, shift_cnt<=shift_cnt+1, stay in SHIFT.
- DONE (1 cycle): done=1, go to IDLE.
- shift_cnt and zero hold their values after DONE until the next accepted start.
- Latency, with start high in cycle 0:
  - ld in cycle 1.
  - Nonzero operand with k leading zeros: k shl_en pulses in cycles 2..k+1; done in cycle k+3.
  - Zero operand: done in cycle 2, no shl_en pulses.
- Back-to-back: start in the cycle after done is accepted; start in the same cycle as done is ignored.
- Arithmetic: shift_cnt saturates at WIDTH-1 and never wraps.

Test Plan:
- The bench models the shift register behaviourally: load on ld, shift left with 0 fill on shl_en; msb_in = model bit 15.
- data_in=0x8000 -> ld in cycle 1; no shl_en; done in cycle 3; shift_cnt=0; zero=0.
- data_in=0x0001 -> 15 consecutive shl_en pulses in cycles 2..16; done in cycle 18; shift_cnt=15; model register=0x8000.
- data_in=0x0000 -> ld in cycle 1; done in cycle 2; zero=1; shift_cnt=0; no shl_en.
- data_in=0x00F0 -> shift_cnt=8; model=0xF000; done in cycle 11. A second start with 0x4000 during busy is ignored; after done, start 0x4000 gives shift_cnt=1.
- Drive rst=0 asynchronously mid-SHIFT (0x0001, cycle 6) -> outputs clear immediately, without waiting for a clock edge; busy=0; a fresh start 0x0100 afterwards yields shift_cnt=7, done in cycle 10.
